// File: rtl/jtpang_dmaarb_pkg.sv
// Shared types for the object-DMA bus arbiter: FSM state encoding and default watchdog limit.
// No logic; imported by the arbiter top and its watchdog.
`timescale 1ns/1ps
package jtpang_dmaarb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GO    = 3'd1,
        ST_REQ   = 3'd2,
        ST_GRANT = 3'd3,
        ST_REL   = 3'd4
    } dma_st_e;

    localparam logic [7:0] TOUT_DEF = 8'd255;

endpackage

// File: rtl/jtpang_dmaarb_wdog.sv
// Watchdog for the DMA arbiter: counts cen ticks while waiting in GO/REQ, restarting on each state entry.
// o_expire is combinational from registered state; o_err is a sticky registered flag cleared only by reset.
`timescale 1ns/1ps
module jtpang_dmaarb_wdog
    import jtpang_dmaarb_pkg::*;
#(
    parameter logic [7:0] TOUT = TOUT_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    cen,
    input  dma_st_e i_state,
    output logic    o_expire,
    output logic    o_err
);

    dma_st_e    r_prev;
    logic [7:0] r_cnt;
    logic       r_err;
    logic       w_run;
    logic       w_entry;

    assign w_run    = (i_state == ST_GO) || (i_state == ST_REQ);
    assign w_entry  = (i_state != r_prev);
    assign o_expire = w_run && !w_entry && (r_cnt == TOUT);
    assign o_err    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= ST_IDLE;
            r_cnt  <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            r_prev <= i_state;
            // A tick landing in the entry cycle already counts toward the limit.
            if (!w_run)
                r_cnt <= 8'd0;
            else if (w_entry)
                r_cnt <= {7'd0, cen};
            else if (cen && (r_cnt != TOUT))
                r_cnt <= r_cnt + 8'd1;
            if (o_expire)
                r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/jtpang_dmaarb.sv
// Z80 / object-DMA bus arbiter; all outputs registered, one clk from trigger edge to dma_go.
// Optional watchdog under JTPANG_DMA_TIMEOUT_EN aborts a stuck GO/REQ and raises tout_err.
`timescale 1ns/1ps
module jtpang_dmaarb
    import jtpang_dmaarb_pkg::*;
#(
    parameter logic [7:0] TOUT = TOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       dma_cs,
    input  logic       wr_n,
    input  logic       busrq,
    output logic       busak_n,
    output logic       dma_go,
    output logic       cpu_busrq_n,
    input  logic       cpu_busak_n,
    output logic       dma_busy,
    output logic [7:0] dma_cnt,
    output logic       tout_err
);

    dma_st_e    r_state;
    logic       r_wr_q;
    logic       r_trig;
    logic       r_busak_n;
    logic       r_dma_go;
    logic       r_cpu_busrq_n;
    logic       r_busy;
    logic [7:0] r_cnt;
    logic       w_wr;
    logic       w_tout;

    assign w_wr        = dma_cs & ~wr_n;
    assign busak_n     = r_busak_n;
    assign dma_go      = r_dma_go;
    assign cpu_busrq_n = r_cpu_busrq_n;
    assign dma_busy    = r_busy;
    assign dma_cnt     = r_cnt;

`ifdef JTPANG_DMA_TIMEOUT_EN
    logic w_err;

    jtpang_dmaarb_wdog #(.TOUT(TOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .i_state  (r_state),
        .o_expire (w_tout),
        .o_err    (w_err)
    );

    assign tout_err = w_err;
`else
    logic [8:0] w_unused;

    assign w_unused = {cen, TOUT};
    assign w_tout   = 1'b0;
    assign tout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wr_q        <= 1'b0;
            r_trig        <= 1'b0;
            r_busak_n     <= 1'b1;
            r_dma_go      <= 1'b0;
            r_cpu_busrq_n <= 1'b1;
            r_busy        <= 1'b0;
            r_cnt         <= 8'd0;
        end else begin
            r_wr_q <= w_wr;
            r_trig <= w_wr & ~r_wr_q;
            // r_trig is only looked at in IDLE, so writes during a transfer are dropped.
            case (r_state)
                ST_IDLE: begin
                    if (busrq) begin
                        r_state       <= ST_REQ;
                        r_cpu_busrq_n <= 1'b0;
                        r_busy        <= 1'b1;
                    end else if (r_trig) begin
                        r_state  <= ST_GO;
                        r_dma_go <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_GO: begin
                    if (busrq) begin
                        r_state       <= ST_REQ;
                        r_dma_go      <= 1'b0;
                        r_cpu_busrq_n <= 1'b0;
                    end else if (w_tout) begin
                        r_state  <= ST_IDLE;
                        r_dma_go <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!cpu_busak_n) begin
                        r_state   <= ST_GRANT;
                        r_busak_n <= 1'b0;
                    end else if (w_tout) begin
                        r_state       <= ST_IDLE;
                        r_cpu_busrq_n <= 1'b1;
                        r_busy        <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Also let go if the Z80 withdraws its acknowledge, keeping the bus exclusive.
                    if (!busrq || cpu_busak_n) begin
                        r_state       <= ST_REL;
                        r_busak_n     <= 1'b1;
                        r_cpu_busrq_n <= 1'b1;
                    end
                end
                ST_REL: begin
                    if (cpu_busak_n) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_busak_n     <= 1'b1;
                    r_dma_go      <= 1'b0;
                    r_cpu_busrq_n <= 1'b1;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtpang_dmaarb.sv
// Bench for jtpang_dmaarb: directed and randomized transfers scored against per-transfer timing arithmetic.
// Define JTPANG_DMA_TIMEOUT_EN on the whole build to exercise the watchdog instead of the indefinite wait.
`timescale 1ns/1ps
module tb_jtpang_dmaarb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       dma_cs = 1'b0;
    logic       wr_n = 1'b1;
    logic       busrq = 1'b0;
    logic       cpu_busak_n = 1'b1;
    logic       busak_n;
    logic       dma_go;
    logic       cpu_busrq_n;
    logic       dma_busy;
    logic [7:0] dma_cnt;
    logic       tout_err;

    int n_chk = 0;
    int n_pass = 0;
    int m_cnt = 0;
    int m_err = 0;

    jtpang_dmaarb #(.TOUT(8'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .dma_cs      (dma_cs),
        .wr_n        (wr_n),
        .busrq       (busrq),
        .busak_n     (busak_n),
        .dma_go      (dma_go),
        .cpu_busrq_n (cpu_busrq_n),
        .cpu_busak_n (cpu_busak_n),
        .dma_busy    (dma_busy),
        .dma_cnt     (dma_cnt),
        .tout_err    (tout_err)
    );

    always #10 clk = ~clk;

    // CPU clock enable: one pulse every 6 clk.
    initial begin
        forever begin
            repeat (5) @(posedge clk);
            #2 cen = 1'b1;
            @(posedge clk);
            #2 cen = 1'b0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer on a timeline of clk edges k = 0,1,2,...: optional write at k=0, busrq high over
    // [d_rq, d_off), cpu_busak_n low over [d_ack, d_rel), optional extra write during GRANT.
    task automatic xfer(input bit wr, input int d_rq, input int d_ack, input int d_off,
                        input int d_rel, input bit disc);
        int n_go, n_ak, first_ak, n_crq, n_busy, n_bad, busy_from;
        n_go = 0; n_ak = 0; first_ak = -1; n_crq = 0; n_busy = 0; n_bad = 0;
        for (int k = 0; k <= d_rel + 4; k++) begin
            wr_n        = !((wr && k == 0) || (disc && k == d_ack + 1));
            dma_cs      = !wr_n ? 1'b1 : 1'($urandom_range(0, 1));
            busrq       = (k >= d_rq) && (k < d_off);
            cpu_busak_n = !((k >= d_ack) && (k < d_rel));
            step();
            if (dma_go) n_go++;
            if (!busak_n) begin
                n_ak++;
                if (first_ak < 0) first_ak = k;
            end
            if (!cpu_busrq_n) n_crq++;
            if (dma_busy) n_busy++;
            if (!busak_n && cpu_busak_n) n_bad++;
        end
        wr_n = 1'b1; dma_cs = 1'b0; busrq = 1'b0; cpu_busak_n = 1'b1;
        m_cnt = (m_cnt + 1) % 256;
        // A write is acted on one clk after the edge that registers it, unless busrq is already up.
        busy_from = wr ? ((d_rq < 1) ? d_rq : 1) : d_rq;
        chk("dma_go_cycles", n_go, (wr && d_rq >= 2) ? d_rq - 1 : 0);
        chk("busak_low_cycles", n_ak, d_off - d_ack);
        chk("busak_first_low", first_ak, d_ack);
        chk("cpu_busrq_low_cycles", n_crq, d_off - d_rq);
        chk("busy_cycles", n_busy, d_rel - busy_from);
        chk("exclusivity_violations", n_bad, 0);
        chk("dma_cnt", dma_cnt, m_cnt);
        chk("tout_err", tout_err, m_err);
    endtask

    initial begin
        int r_wr, r_rq, r_ack, r_off, r_rel, r_disc;

        step();
        step();
        chk("rst_busak_n", busak_n, 1);
        chk("rst_cpu_busrq_n", cpu_busrq_n, 1);
        chk("rst_dma_go", dma_go, 0);
        chk("rst_dma_busy", dma_busy, 0);
        chk("rst_dma_cnt", dma_cnt, 0);
        chk("rst_tout_err", tout_err, 0);
        rst_n = 1'b1;
        step();
        step();

        xfer(1, 3, 5, 40, 42, 0);
        xfer(0, 0, 2, 10, 12, 0);
        xfer(1, 2, 4, 15, 17, 1);

`ifdef JTPANG_DMA_TIMEOUT_EN
        for (int k = 0; k <= 40; k++) begin
            wr_n   = !(k == 0);
            dma_cs = (k == 0);
            busrq  = 1'b0;
            step();
            if (k == 3) chk("wd_go_before_limit", dma_go, 1);
        end
        wr_n = 1'b1; dma_cs = 1'b0;
        m_err = 1;
        chk("wd_busy", dma_busy, 0);
        chk("wd_dma_go", dma_go, 0);
        chk("wd_cpu_busrq_n", cpu_busrq_n, 1);
        chk("wd_tout_err", tout_err, 1);
        chk("wd_dma_cnt", dma_cnt, m_cnt);
`else
        xfer(1, 44, 47, 55, 58, 0);
`endif

        // Reset while holding the bus must release it without a clock edge.
        busrq = 1'b1;
        step();
        cpu_busak_n = 1'b0;
        step();
        step();
        chk("grant_busak_n", busak_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busak_n", busak_n, 1);
        chk("async_rst_cpu_busrq_n", cpu_busrq_n, 1);
        chk("async_rst_busy", dma_busy, 0);
        chk("async_rst_dma_cnt", dma_cnt, 0);
        busrq = 1'b0;
        cpu_busak_n = 1'b1;
        step();
        rst_n = 1'b1;
        m_cnt = 0;
        m_err = 0;
        step();
        step();
        chk("post_rst_busy", dma_busy, 0);
        chk("post_rst_dma_go", dma_go, 0);
        chk("post_rst_tout_err", tout_err, 0);

        for (int t = 0; t < 256; t++) begin
            r_wr   = $urandom_range(0, 1);
            r_rq   = $urandom_range(0, 5);
            r_ack  = r_rq + $urandom_range(1, 4);
            r_off  = r_ack + $urandom_range(5, 12);
            r_rel  = r_off + $urandom_range(1, 4);
            r_disc = $urandom_range(0, 1);
            xfer(r_wr[0], r_rq, r_ack, r_off, r_rel, r_disc[0]);
        end
        chk("wrap_dma_cnt", dma_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
